reset_sequencer: RTL and testbench

// Board-level reset controller; replaces the ad-hoc auto-reset counter plus button OR in top-level wrappers.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/sync_debounce.sv | 55 +++++
 rtl/reset_sequencer.sv | 158 +++++++++++++++
 tb/tb_reset_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the staged reset sequencer.
// Counter-width helper keeps every counter at least one bit wide.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_BTN = 2'd1,
        CAUSE_SW  = 2'd2,
        CAUSE_WD  = 2'd3
    } cause_t;

    function automatic int cnt_w(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// SoC-facing side of the reset sequencer: request/kick inputs,
// staged resets, ready flag and last reset cause.
interface reset_sequencer_if
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT = 3
);
    logic               sw_req_i;
    logic               wd_kick_i;
    logic [NUM_OUT-1:0] reset_o;
    logic               ready_o;
    cause_t             cause_o;

    modport master (
        input  sw_req_i,
        input  wd_kick_i,
        output reset_o,
        output ready_o,
        output cause_o
    );

    modport slave (
        output sw_req_i,
        output wd_kick_i,
        input  reset_o,
        input  ready_o,
        input  cause_o
    );
endinterface

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a stable-count filter.
// CYCLES<=1 leaves the synchroniser output unfiltered.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int STAGES = 2,
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;
    logic              sync_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign sync_s = sync_q[STAGES-1];

    if (CYCLES <= 1) begin : g_bypass
        assign q_o = sync_s;
    end else begin : g_filter
        localparam int CW = cnt_w(CYCLES);
        localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          db_q, db_d;

        // Any cycle agreeing with the filtered value restarts the count.
        always_comb begin
            cnt_d = '0;
            db_d  = db_q;
            if (sync_s != db_q) begin
                if (cnt_q == LAST) db_d  = sync_s;
                else               cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                db_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                db_q  <= db_d;
            end
        end

        assign q_o = db_q;
    end
endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: HOLD until lock is stable, staged release, cause report.
// Optional watchdog trigger is built only with RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_OUT         = 3,
    parameter int HOLD_CYCLES     = 31,
    parameter int STAGE_GAP       = 16,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int WD_TIMEOUT      = 25000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              locked_i,
    input  logic              btn_i,
    reset_sequencer_if.master bus
);
    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int GW = cnt_w(STAGE_GAP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);

    state_t             state_q, state_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [NUM_OUT-1:0] rst_q, rst_d, rst_next;
    logic               ready_q, ready_d;
    cause_t             cause_q, cause_d, trig_cause;
    logic               locked_s, btn_db, btn_db_q;
    logic               btn_rise, wd_to, trig;

    sync_debounce #(.STAGES(2), .CYCLES(1)) u_lock (
        .clk   (clk),
        .reset (reset),
        .d_i   (locked_i),
        .q_o   (locked_s)
    );

    sync_debounce #(.STAGES(2), .CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_i),
        .q_o   (btn_db)
    );

    assign btn_rise = btn_db & ~btn_db_q;
    assign rst_next = rst_q << 1;

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WW = cnt_w(WD_TIMEOUT);
    localparam logic [WW-1:0] WD_LAST = WW'(WD_TIMEOUT - 1);

    logic [WW-1:0] wd_q, wd_d;

    assign wd_to = (state_q == RUN) && (wd_q == WD_LAST);

    always_comb begin
        wd_d = '0;
        if (state_q == RUN && !trig && !bus.wd_kick_i)
            wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + WW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    localparam int unused_wd_timeout = WD_TIMEOUT;
    logic unused_wd_kick;

    assign unused_wd_kick = bus.wd_kick_i;
    assign wd_to          = 1'b0;
`endif

    // Overlapping triggers resolve lock > watchdog > button > software.
    always_comb begin
        trig       = 1'b1;
        trig_cause = CAUSE_POR;
        priority case (1'b1)
            !locked_s:    trig_cause = CAUSE_POR;
            wd_to:        trig_cause = CAUSE_WD;
            btn_rise:     trig_cause = CAUSE_BTN;
            bus.sw_req_i: trig_cause = CAUSE_SW;
            default:      trig       = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        cause_d = cause_q;
        unique case (state_q)
            HOLD: begin
                if (locked_s && !btn_db) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        gap_d   = '0;
                        rst_d   = rst_next;
                        ready_d = (rst_next == '0);
                        state_d = (rst_next == '0) ? RUN : RELEASE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end else begin
                    hold_d = '0;
                end
            end
            RELEASE: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    rst_d   = rst_next;
                    ready_d = (rst_next == '0);
                    state_d = (rst_next == '0) ? RUN : RELEASE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            RUN: ;
            default: state_d = HOLD;
        endcase

        if (trig && state_q != HOLD) begin
            state_d = HOLD;
            hold_d  = '0;
            gap_d   = '0;
            rst_d   = '1;
            ready_d = 1'b0;
            cause_d = trig_cause;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= HOLD;
            hold_q   <= '0;
            gap_q    <= '0;
            rst_q    <= '1;
            ready_q  <= 1'b0;
            cause_q  <= CAUSE_POR;
            btn_db_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            cause_q  <= cause_d;
            btn_db_q <= btn_db;
        end
    end

    assign bus.reset_o = rst_q;
    assign bus.ready_o = ready_q;
    assign bus.cause_o = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: each scenario queues the output changes it expects
// (edge number and value); a negedge monitor pops and compares them.
module tb_reset_sequencer;
    typedef struct {
        int         cyc;
        logic [5:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic locked_i = 1'b1;
    logic btn_i = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;
    logic [5:0] prev;
    exp_t sb[$];

    reset_sequencer_if #(.NUM_OUT(3)) bus ();

    reset_sequencer #(
        .NUM_OUT(3),
        .HOLD_CYCLES(8),
        .STAGE_GAP(4),
        .DEBOUNCE_CYCLES(5),
        .WD_TIMEOUT(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .locked_i(locked_i),
        .btn_i(btn_i),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [5:0] cur;
        exp_t e;
        cur = {bus.reset_o, bus.ready_o, bus.cause_o};
        if (mon_en && cur !== prev) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change cyc=%0d got %b prev %b",
                         cyc, cur, prev);
            end else begin
                e = sb.pop_front();
                if (e.cyc != cyc || e.val !== cur) begin
                    fails++;
                    $display("FAIL sb_event got %b @%0d want %b @%0d",
                             cur, cyc, e.val, e.cyc);
                end
            end
            prev = cur;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] r,
                        input logic d, input logic [1:0] ca);
        sb.push_back('{c, {r, d, ca}});
    endtask

    task automatic test_reset();
        int n;
        #2;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.reset_o !== 3'b111) begin
            fails++;
            $display("FAIL por_reset_o got %b want 111", bus.reset_o);
        end
        checks++;
        if (bus.ready_o !== 1'b0) begin
            fails++;
            $display("FAIL por_ready got %b want 0", bus.ready_o);
        end
        checks++;
        if (bus.cause_o !== 2'd0) begin
            fails++;
            $display("FAIL por_cause got %0d want 0", bus.cause_o);
        end
        prev   = {3'b111, 1'b0, 2'd0};
        mon_en = 1'b1;
        reset  = 1'b0;
        n      = cyc;
        push(n + 10, 3'b110, 1'b0, 2'd0);
        push(n + 14, 3'b100, 1'b0, 2'd0);
        push(n + 18, 3'b000, 1'b1, 2'd0);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL por_drain pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_lock_glitch();
        int n;
        tick(1);
        n = cyc;
        locked_i = 1'b0;
        push(n + 3, 3'b111, 1'b0, 2'd0);
        push(n + 11, 3'b110, 1'b0, 2'd0);
        push(n + 15, 3'b100, 1'b0, 2'd0);
        push(n + 19, 3'b000, 1'b1, 2'd0);
        tick(1);
        locked_i = 1'b1;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL lock_drain pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_button();
        int n;
        for (int p = 0; p < 2; p++) begin
            tick(1);
            btn_i = 1'b1;
            tick(3);
            btn_i = 1'b0;
            tick(6);
        end
        checks++;
        if (bus.reset_o !== 3'b000 || bus.ready_o !== 1'b1) begin
            fails++;
            $display("FAIL btn_bounce got %b/%b want 000/1",
                     bus.reset_o, bus.ready_o);
        end
        tick(1);
        n = cyc;
        btn_i = 1'b1;
        push(n + 8, 3'b111, 1'b0, 2'd1);
        tick(20);
        btn_i = 1'b0;
        push(n + 35, 3'b110, 1'b0, 2'd1);
        push(n + 39, 3'b100, 1'b0, 2'd1);
        push(n + 43, 3'b000, 1'b1, 2'd1);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL btn_drain pending %0d want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (bus.cause_o !== 2'd1) begin
            fails++;
            $display("FAIL btn_cause got %0d want 1", bus.cause_o);
        end
    endtask

    task automatic test_sw();
        int n;
        tick(1);
        n = cyc;
        bus.sw_req_i = 1'b1;
        push(n + 1, 3'b111, 1'b0, 2'd2);
        tick(1);
        bus.sw_req_i = 1'b0;
        tick(2);
        bus.sw_req_i = 1'b1;
        tick(1);
        bus.sw_req_i = 1'b0;
        push(n + 9, 3'b110, 1'b0, 2'd2);
        push(n + 13, 3'b100, 1'b0, 2'd2);
        push(n + 17, 3'b000, 1'b1, 2'd2);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sw_drain pending %0d want 0", sb.size());
            sb.delete();
        end
        checks++;
        if (bus.cause_o !== 2'd2) begin
            fails++;
            $display("FAIL sw_cause got %0d want 2", bus.cause_o);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        tick(1);
        n = cyc;
        locked_i = 1'b0;
        tick(1);
        locked_i = 1'b1;
        tick(1);
        bus.sw_req_i = 1'b1;
        push(n + 3, 3'b111, 1'b0, 2'd0);
        push(n + 11, 3'b110, 1'b0, 2'd0);
        tick(1);
        bus.sw_req_i = 1'b0;
        tick(9);
        bus.sw_req_i = 1'b1;
        push(n + 13, 3'b111, 1'b0, 2'd2);
        tick(1);
        bus.sw_req_i = 1'b0;
        push(n + 21, 3'b110, 1'b0, 2'd2);
        push(n + 25, 3'b100, 1'b0, 2'd2);
        push(n + 29, 3'b000, 1'b1, 2'd2);
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL simul_drain pending %0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_watchdog();
`ifdef RESET_SEQ_WATCHDOG_EN
        int k;
        tick(1);
        bus.wd_kick_i = 1'b1;
        tick(1);
        bus.wd_kick_i = 1'b0;
        k = cyc;
        for (int r = 0; r < 3; r++) begin
            tick(98);
            bus.wd_kick_i = 1'b1;
            tick(1);
            bus.wd_kick_i = 1'b0;
            k = cyc;
        end
        checks++;
        if (bus.reset_o !== 3'b000 || bus.ready_o !== 1'b1) begin
            fails++;
            $display("FAIL wd_kicked got %b/%b want 000/1",
                     bus.reset_o, bus.ready_o);
        end
        push(k + 100, 3'b111, 1'b0, 2'd3);
        push(k + 108, 3'b110, 1'b0, 2'd3);
        push(k + 112, 3'b100, 1'b0, 2'd3);
        push(k + 116, 3'b000, 1'b1, 2'd3);
        for (int i = 0; i < 140 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL wd_drain pending %0d want 0", sb.size());
            sb.delete();
        end
`else
        tick(1000);
        checks++;
        if (bus.reset_o !== 3'b000 || bus.ready_o !== 1'b1) begin
            fails++;
            $display("FAIL nowd_run got %b/%b want 000/1",
                     bus.reset_o, bus.ready_o);
        end
        checks++;
        if (bus.cause_o !== 2'd2) begin
            fails++;
            $display("FAIL nowd_cause got %0d want 2", bus.cause_o);
        end
`endif
    endtask

    initial begin
        bus.sw_req_i  = 1'b0;
        bus.wd_kick_i = 1'b0;
        test_reset();
        test_lock_glitch();
        test_button();
        test_sw();
        test_simultaneous();
        test_watchdog();
        tick(5);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
